// File: rtl/butoane_filtru.sv
// Switch/button conditioner: per-channel synchroniser, counter debounce, rise/fall strobes.
// Define BUTOANE_FILTRU_TOGGLE_EN to enable the per-channel toggle output mode (mode_i).
module butoane_filtru #(
   parameter int N           = 2,
   parameter int DEB_CYCLES  = 500000,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk_i,
   input  logic         reset_ni,
   input  logic [N-1:0] sw_i,
   input  logic [N-1:0] mode_i,
   output logic [N-1:0] level_o,
   output logic [N-1:0] rise_o,
   output logic [N-1:0] fall_o,
   output logic [N-1:0] out_o
);

   localparam int CW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_WAIT   = 1'b1
   } deb_state_t;

`ifndef BUTOANE_FILTRU_TOGGLE_EN
   logic unused_mode;
   assign unused_mode = ^mode_i;
`endif

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_reg;
         logic                   s;
         deb_state_t             state_reg;
         logic [CW-1:0]          cnt_reg;
         logic                   level_reg;
         logic                   rise_reg;
         logic                   fall_reg;
         logic                   commit;
         logic                   level_next;

         always_ff @(posedge clk_i) begin
            if (!reset_ni) begin
               sync_reg <= '0;
            end else begin
               sync_reg <= {sync_reg[SYNC_STAGES-2:0], sw_i[gi]};
            end
         end

         assign s = sync_reg[SYNC_STAGES-1];

         // The DEB_CYCLES-th consecutive contrary sample flips the level.
         assign commit     = (state_reg == ST_WAIT) && (s != level_reg) && (cnt_reg == CNT_LAST);
         assign level_next = level_reg ^ commit;

`ifdef BUTOANE_FILTRU_TOGGLE_EN
         logic out_reg;
`endif

         always_ff @(posedge clk_i) begin
            if (!reset_ni) begin
               state_reg <= ST_STABLE;
               cnt_reg   <= '0;
               level_reg <= 1'b0;
               rise_reg  <= 1'b0;
               fall_reg  <= 1'b0;
`ifdef BUTOANE_FILTRU_TOGGLE_EN
               out_reg   <= 1'b0;
`endif
            end else begin
               rise_reg <= 1'b0;
               fall_reg <= 1'b0;
               case (state_reg)
                  ST_STABLE: begin
                     if (s != level_reg) begin
                        state_reg <= ST_WAIT;
                        cnt_reg   <= CW'(1);
                     end else begin
                        cnt_reg   <= '0;
                     end
                  end
                  ST_WAIT: begin
                     if (s == level_reg) begin
                        state_reg <= ST_STABLE;
                        cnt_reg   <= '0;
                     end else if (commit) begin
                        level_reg <= ~level_reg;
                        rise_reg  <= ~level_reg;
                        fall_reg  <= level_reg;
                        state_reg <= ST_STABLE;
                        cnt_reg   <= '0;
                     end else begin
                        cnt_reg   <= cnt_reg + CW'(1);
                     end
                  end
                  default: begin
                     state_reg <= ST_STABLE;
                     cnt_reg   <= '0;
                  end
               endcase
`ifdef BUTOANE_FILTRU_TOGGLE_EN
               // Toggle mode flips only on a rise commit; level mode tracks the new level.
               if (mode_i[gi]) begin
                  if (commit && !level_reg) begin
                     out_reg <= ~out_reg;
                  end
               end else begin
                  out_reg <= level_next;
               end
`endif
            end
         end

         assign level_o[gi] = level_reg;
         assign rise_o[gi]  = rise_reg;
         assign fall_o[gi]  = fall_reg;
`ifdef BUTOANE_FILTRU_TOGGLE_EN
         assign out_o[gi]   = out_reg;
`else
         assign out_o[gi]   = level_reg;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_butoane_filtru.sv
// Self-checking bench for butoane_filtru: run-length reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_butoane_filtru;

   localparam int N   = 2;
   localparam int DEB = 4;
   localparam int SS  = 2;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [N-1:0] sw = '0;
   logic [N-1:0] mode = '0;
   logic [N-1:0] level_o, rise_o, fall_o, out_o;

   always #5 clk = ~clk;

   butoane_filtru #(.N(N), .DEB_CYCLES(DEB), .SYNC_STAGES(SS)) dut (
      .clk_i   (clk),
      .reset_ni(reset_n),
      .sw_i    (sw),
      .mode_i  (mode),
      .level_o (level_o),
      .rise_o  (rise_o),
      .fall_o  (fall_o),
      .out_o   (out_o)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: sw reaches the debouncer SS samples later; level flips once DEB
   // consecutive samples disagree with it.
   logic [SS-1:0][N-1:0] m_sync = '0;
   logic [N-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_out = '0;
   int           m_run [N];

   initial for (int i = 0; i < N; i++) m_run[i] = 0;

   always @(posedge clk) begin : model
      logic [N-1:0] s, lv, rs, fl, ot;
      if (!reset_n) begin
         m_sync  <= '0;
         m_level <= '0;
         m_rise  <= '0;
         m_fall  <= '0;
         m_out   <= '0;
         for (int i = 0; i < N; i++) m_run[i] <= 0;
      end else begin
         s  = m_sync[SS-1];
         lv = m_level;
         rs = '0;
         fl = '0;
         ot = m_out;
         for (int ch = 0; ch < N; ch++) begin
            int r;
            r = (s[ch] != lv[ch]) ? m_run[ch] + 1 : 0;
            if (r == DEB) begin
               r      = 0;
               lv[ch] = ~lv[ch];
               rs[ch] = lv[ch];
               fl[ch] = ~lv[ch];
            end
            m_run[ch] <= r;
`ifdef BUTOANE_FILTRU_TOGGLE_EN
            if (mode[ch]) begin
               if (rs[ch]) ot[ch] = ~ot[ch];
            end else begin
               ot[ch] = lv[ch];
            end
`else
            ot[ch] = lv[ch];
`endif
         end
         m_sync  <= {m_sync[SS-2:0], sw};
         m_level <= lv;
         m_rise  <= rs;
         m_fall  <= fl;
         m_out   <= ot;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("level_o", 32'(level_o), 32'(m_level));
         check("rise_o",  32'(rise_o),  32'(m_rise));
         check("fall_o",  32'(fall_o),  32'(m_fall));
         check("out_o",   32'(out_o),   32'(m_out));
      end
   end

   // Event counters for directed checks
   int rise0_cnt = 0, rise1_cnt = 0, fall1_cnt = 0, lvl1_hi = 0, out_ne_lvl = 0;
   always @(negedge clk) begin
      rise0_cnt  += int'(rise_o[0]);
      rise1_cnt  += int'(rise_o[1]);
      fall1_cnt  += int'(fall_o[1]);
      lvl1_hi    += int'(level_o[1]);
      out_ne_lvl += int'(out_o != level_o);
   end

   task automatic drive(input logic r, input logic [N-1:0] s, input logic [N-1:0] m);
      @(posedge clk);
      #2;
      reset_n = r;
      sw      = s;
      mode    = m;
      $display("[TB] drive rst_n=%0b sw=%b mode=%b", r, s, m);
   endtask

   task automatic idle(input int n, input logic [N-1:0] s, input logic [N-1:0] m);
      for (int i = 0; i < n; i++) drive(1'b1, s, m);
   endtask

   // Two clean press/release cycles on channel 1; returns out_o[1] after each phase.
   task automatic press_release(input logic [N-1:0] m, output logic [3:0] outs);
      for (int k = 0; k < 4; k++) begin
         idle(10, (k % 2 == 0) ? 2'b10 : 2'b00, m);
         @(negedge clk);
         outs[k] = out_o[1];
      end
   endtask

   initial begin
      logic [3:0]  outs;
      logic [3:0]  exp_outs;
      logic [7:0]  bounce;
      logic [N-1:0] rsw;
      logic [N-1:0] rmode;

      // Reset and clean edge
      drive(1'b0, 2'b00, 2'b00);
      chk_en = 1'b1;
      drive(1'b0, 2'b00, 2'b00);
      drive(1'b0, 2'b00, 2'b00);
      drive(1'b1, 2'b00, 2'b00);
      @(negedge clk);
      check("reset_level", 32'(level_o), 32'd0);
      check("reset_out",   32'(out_o),   32'd0);
      check("reset_strobe", 32'({rise_o, fall_o}), 32'd0);
      idle(3, 2'b00, 2'b00);
      rise0_cnt = 0;
      drive(1'b1, 2'b01, 2'b00);
      repeat (6) @(negedge clk);
      check("clean_level_early", 32'(level_o[0]), 32'd0);
      @(negedge clk);
      check("clean_level_e0p5", 32'(level_o[0]), 32'd1);
      check("clean_out_e0p5",   32'(out_o[0]),   32'd1);
      check("clean_rise_e0p5",  32'(rise_o[0]),  32'd1);
      check("clean_ch1_idle",   32'(level_o[1]), 32'd0);
      @(negedge clk);
      check("clean_rise_once",  32'(rise_o[0]),  32'd0);
      idle(6, 2'b01, 2'b00);
      check("clean_rise_count", 32'(rise0_cnt), 32'd1);

      // Bounce rejection
      idle(10, 2'b00, 2'b00);
      check("bounce_pre_low", 32'(level_o[0]), 32'd0);
      rise0_cnt = 0;
      bounce = 8'b1111_0111;  // applied LSB first: 1,1,1,0,1,1,1,1
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, {1'b0, bounce[i]}, 2'b00);
         if (i == 5) check("bounce_no_early_commit", 32'(rise0_cnt), 32'd0);
      end
      idle(6, 2'b01, 2'b00);
      check("bounce_level", 32'(level_o[0]), 32'd1);
      check("bounce_rise_count", 32'(rise0_cnt), 32'd1);

      // Short glitch on channel 1
      rise1_cnt = 0; fall1_cnt = 0; lvl1_hi = 0;
      idle(3, 2'b11, 2'b00);
      idle(10, 2'b01, 2'b00);
      check("glitch_level1", 32'(lvl1_hi),   32'd0);
      check("glitch_rise1",  32'(rise1_cnt), 32'd0);
      check("glitch_fall1",  32'(fall1_cnt), 32'd0);

      // Reset mid-WAIT
      idle(10, 2'b00, 2'b00);
      rise0_cnt = 0;
      drive(1'b1, 2'b01, 2'b00);
      drive(1'b1, 2'b01, 2'b00);
      drive(1'b0, 2'b01, 2'b00);
      @(negedge clk);
      check("rstwait_strobe_in_reset", 32'({rise_o, fall_o}), 32'd0);
      drive(1'b1, 2'b01, 2'b00);
      repeat (6) @(negedge clk);
      check("rstwait_no_early_rise", 32'(rise0_cnt), 32'd0);
      @(negedge clk);
      check("rstwait_rise_at_latency", 32'(rise_o[0]), 32'd1);
      idle(6, 2'b01, 2'b00);
      check("rstwait_rise_count", 32'(rise0_cnt), 32'd1);

      // Toggle scenario (or level passthrough when toggle support is absent)
      idle(10, 2'b00, 2'b00);
      out_ne_lvl = 0;
`ifdef BUTOANE_FILTRU_TOGGLE_EN
      press_release(2'b10, outs);
      exp_outs = 4'b0011;  // after press1, rel1, press2, rel2 (LSB first): 1,1,0,0
      check("toggle_out1_seq", 32'(outs), 32'(exp_outs));
`else
      press_release(2'b11, outs);
      exp_outs = 4'b0101;  // follows level: 1,0,1,0
      check("level_out1_seq", 32'(outs), 32'(exp_outs));
      check("out_eq_level", 32'(out_ne_lvl), 32'd0);
`endif

      // Randomized phase
      rsw = '0;
      rmode = '0;
      for (int i = 0; i < 2000; i++) begin
         for (int ch = 0; ch < N; ch++)
            if ($urandom_range(5) == 0) rsw[ch] = ~rsw[ch];
         if ($urandom_range(39) == 0) rmode = N'($urandom);
         drive(($urandom_range(199) == 0) ? 1'b0 : 1'b1, rsw, rmode);
      end
      @(negedge clk);
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
